// File: rtl/ram8x8_arbiter.sv
// Two-requester arbiter and single-word access sequencer for a shared 8x8 RAM.
// The RAM is assumed to read combinationally from ram_addr_o and write on the rising edge.
module ram8x8_arbiter #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              clock_i,
    input  logic              clear_i,

    input  logic              req_a_i,
    input  logic              we_a_i,
    input  logic [ADDR_W-1:0] addr_a_i,
    input  logic [DATA_W-1:0] wdata_a_i,
    output logic              ack_a_o,

    input  logic              req_b_i,
    input  logic              we_b_i,
    input  logic [ADDR_W-1:0] addr_b_i,
    input  logic [DATA_W-1:0] wdata_b_i,
    output logic              ack_b_o,

    output logic [DATA_W-1:0] rd_data_o,
    output logic              busy_o,

    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_rw_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StAck   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                last_b_q, last_b_d;   // 1 = B was granted most recently
    logic                win_b_q, win_b_d;     // owner of the transaction in flight
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                ack_a_q, ack_a_d;
    logic                ack_b_q, ack_b_d;
    logic                pick_b;

    // B wins when it is the only requester, or on a round-robin tie after A went last.
    always_comb begin
        pick_b = 1'b0;
        if (req_b_i) begin
            if (!req_a_i) begin
                pick_b = 1'b1;
            end else if (FIXED_PRIO == 0) begin
                pick_b = !last_b_q;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_b_d  = last_b_q;
        win_b_d   = win_b_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        ack_a_d   = 1'b0;
        ack_b_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_a_i || req_b_i) begin
                    win_b_d  = pick_b;
                    last_b_d = pick_b;
                    we_d     = pick_b ? we_b_i    : we_a_i;
                    addr_d   = pick_b ? addr_b_i  : addr_a_i;
                    wdata_d  = pick_b ? wdata_b_i : wdata_a_i;
                    state_d  = StGrant;
                end
            end
            StGrant: begin
                if (!we_q) begin
                    rd_data_d = ram_rdata_i;
                end
                ack_a_d = !win_b_q;
                ack_b_d = win_b_q;
                state_d = StAck;
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (clear_i) begin
            state_q   <= StIdle;
            last_b_q  <= 1'b1;
            win_b_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_b_q  <= last_b_d;
            win_b_q   <= win_b_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
        end
    end

    // Gating with clear keeps a write in flight from landing at the aborting edge.
    assign ram_rw_o    = (state_q == StGrant) && we_q && !clear_i;
    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;
    assign rd_data_o   = rd_data_q;
    assign ack_a_o     = ack_a_q;
    assign ack_b_o     = ack_b_q;
    assign busy_o      = (state_q != StIdle);

`ifndef SYNTHESIS
    a_ack_onehot: assert property (@(posedge clock_i) disable iff (clear_i)
        !(ack_a_o && ack_b_o));
    a_rw_in_grant: assert property (@(posedge clock_i)
        ram_rw_o |-> (state_q == StGrant));
`endif

endmodule

// File: tb/tb_ram8x8_arbiter.sv
// Bench for ram8x8_arbiter: one round-robin and one fixed-priority instance, each on its own
// RAM, checked cycle by cycle against a transaction-level reference model.
module tb_ram8x8_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          clear   [2];
    logic          req_a   [2];
    logic          we_a    [2];
    logic [AW-1:0] addr_a  [2];
    logic [DW-1:0] wdata_a [2];
    logic          req_b   [2];
    logic          we_b    [2];
    logic [AW-1:0] addr_b  [2];
    logic [DW-1:0] wdata_b [2];
    logic          ack_a   [2];
    logic          ack_b   [2];
    logic          busy    [2];
    logic          ram_rw  [2];
    logic [AW-1:0] ram_addr  [2];
    logic [DW-1:0] ram_wdata [2];
    logic [DW-1:0] ram_rdata [2];
    logic [DW-1:0] rd_data   [2];
    logic [DW-1:0] ram [2][8];
    logic          zero_ram;

    ram8x8_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIXED_PRIO(0)) u_rr (
        .clock_i(clk), .clear_i(clear[0]),
        .req_a_i(req_a[0]), .we_a_i(we_a[0]), .addr_a_i(addr_a[0]), .wdata_a_i(wdata_a[0]),
        .ack_a_o(ack_a[0]),
        .req_b_i(req_b[0]), .we_b_i(we_b[0]), .addr_b_i(addr_b[0]), .wdata_b_i(wdata_b[0]),
        .ack_b_o(ack_b[0]),
        .rd_data_o(rd_data[0]), .busy_o(busy[0]),
        .ram_addr_o(ram_addr[0]), .ram_rw_o(ram_rw[0]), .ram_wdata_o(ram_wdata[0]),
        .ram_rdata_i(ram_rdata[0])
    );

    ram8x8_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIXED_PRIO(1)) u_fp (
        .clock_i(clk), .clear_i(clear[1]),
        .req_a_i(req_a[1]), .we_a_i(we_a[1]), .addr_a_i(addr_a[1]), .wdata_a_i(wdata_a[1]),
        .ack_a_o(ack_a[1]),
        .req_b_i(req_b[1]), .we_b_i(we_b[1]), .addr_b_i(addr_b[1]), .wdata_b_i(wdata_b[1]),
        .ack_b_o(ack_b[1]),
        .rd_data_o(rd_data[1]), .busy_o(busy[1]),
        .ram_addr_o(ram_addr[1]), .ram_rw_o(ram_rw[1]), .ram_wdata_o(ram_wdata[1]),
        .ram_rdata_i(ram_rdata[1])
    );

    // Behavioural RAMs standing in for the two ram8x8 instances.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (zero_ram) begin
                for (int i = 0; i < 8; i++) ram[k][i] <= '0;
            end else if (ram_rw[k]) begin
                ram[k][ram_addr[k]] <= ram_wdata[k];
            end
        end
    end
    assign ram_rdata[0] = ram[0][ram_addr[0]];
    assign ram_rdata[1] = ram[1][ram_addr[1]];

    // Reference model: one outstanding transaction per instance with an age in cycles.
    int            m_age   [2];   // 0 none, 1 granted, 2 acknowledging
    logic          m_who_b [2];
    logic          m_we    [2];
    logic [AW-1:0] m_addr  [2];
    logic [DW-1:0] m_wdata [2];
    logic          m_last_b[2];
    logic [DW-1:0] m_rd    [2];
    logic [DW-1:0] m_mem [2][8];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input int k);
        logic b;
        if (zero_ram) begin
            for (int i = 0; i < 8; i++) m_mem[k][i] = '0;
        end
        if (clear[k]) begin
            m_age[k]    = 0;
            m_we[k]     = 1'b0;
            m_addr[k]   = '0;
            m_wdata[k]  = '0;
            m_rd[k]     = '0;
            m_last_b[k] = 1'b1;
        end else if (m_age[k] == 0) begin
            if (req_a[k] || req_b[k]) begin
                if (req_a[k] && req_b[k]) b = (k == 1) ? 1'b0 : !m_last_b[k];
                else                      b = req_b[k];
                m_who_b[k]  = b;
                m_last_b[k] = b;
                m_we[k]     = b ? we_b[k]    : we_a[k];
                m_addr[k]   = b ? addr_b[k]  : addr_a[k];
                m_wdata[k]  = b ? wdata_b[k] : wdata_a[k];
                m_age[k]    = 1;
            end
        end else if (m_age[k] == 1) begin
            if (m_we[k]) m_mem[k][m_addr[k]] = m_wdata[k];
            else         m_rd[k] = m_mem[k][m_addr[k]];
            m_age[k] = 2;
        end else begin
            m_age[k] = 0;
        end
    endtask

    task automatic check_outputs(input int k);
        check($sformatf("i%0d ack_a", k), ack_a[k], (m_age[k] == 2) && !m_who_b[k]);
        check($sformatf("i%0d ack_b", k), ack_b[k], (m_age[k] == 2) && m_who_b[k]);
        check($sformatf("i%0d busy", k), busy[k], m_age[k] != 0);
        check($sformatf("i%0d ram_rw", k), ram_rw[k], (m_age[k] == 1) && m_we[k] && !clear[k]);
        check($sformatf("i%0d rd_data", k), rd_data[k], m_rd[k]);
        check($sformatf("i%0d ram_addr", k), ram_addr[k], m_addr[k]);
        check($sformatf("i%0d ram_wdata", k), ram_wdata[k], m_wdata[k]);
    endtask

    task automatic step();
        for (int k = 0; k < 2; k++) model_edge(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) check_outputs(k);
    endtask

    // Steps until the selected ack; lat is 99 if it never arrives.
    task automatic wait_ack(input int k, input bit is_b, output int lat, output int rws);
        lat = 0;
        rws = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            lat++;
            if (ram_rw[k]) rws++;
            if (is_b ? ack_b[k] : ack_a[k]) return;
        end
        lat = 99;
    endtask

    task automatic do_reset();
        clear[0] = 1'b1;
        clear[1] = 1'b1;
        step();
        check("reset rw0 c1", ram_rw[0], 1'b0);
        step();
        check("reset rw0 c2", ram_rw[0], 1'b0);
        check("reset busy0", busy[0], 1'b0);
        check("reset rd_data1", rd_data[1], '0);
        clear[0] = 1'b0;
        clear[1] = 1'b0;
    endtask

    initial begin
        int lat, rws, n_a, n_b, prev_t, t, a_ok, b_ok;
        logic prev_who, got_a, got_b;
        logic [DW-1:0] a_data;

        for (int k = 0; k < 2; k++) begin
            req_a[k] = 0; we_a[k] = 0; addr_a[k] = '0; wdata_a[k] = '0;
            req_b[k] = 0; we_b[k] = 0; addr_b[k] = '0; wdata_b[k] = '0;
            m_age[k] = 0; m_who_b[k] = 0; m_we[k] = 0; m_addr[k] = '0; m_wdata[k] = '0;
            m_last_b[k] = 1; m_rd[k] = '0;
            for (int i = 0; i < 8; i++) m_mem[k][i] = '0;
        end
        zero_ram = 1'b1;
        clear[0] = 1'b1;
        clear[1] = 1'b1;
        step();
        zero_ram = 1'b0;
        do_reset();
        step();
        check("post-reset rw0", ram_rw[0], 1'b0);

        // Solo write then read on the round-robin instance.
        req_a[0] = 1; we_a[0] = 1; addr_a[0] = 3'd3; wdata_a[0] = 8'hA5;
        wait_ack(0, 0, lat, rws);
        check("t2 write latency", lat, 2);
        check("t2 rw pulses", rws, 1);
        req_a[0] = 0;
        step();
        req_a[0] = 1; we_a[0] = 0;
        wait_ack(0, 0, lat, rws);
        check("t2 read latency", lat, 2);
        check("t2 read data", rd_data[0], 8'hA5);
        req_a[0] = 0;
        step();

        // Round-robin tie with both requests held.
        do_reset();
        req_a[0] = 1; we_a[0] = 0; addr_a[0] = 3'd1;
        req_b[0] = 1; we_b[0] = 0; addr_b[0] = 3'd2;
        n_a = 0; n_b = 0; prev_t = -1; prev_who = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            step();
            if (ack_a[0] || ack_b[0]) begin
                if (prev_t < 0) check("t3 first ack time", i, 2);
                else            check("t3 ack spacing", i - prev_t, 3);
                check("t3 alternation", ack_b[0], !prev_who);
                prev_who = ack_b[0];
                prev_t = i;
                if (ack_a[0]) n_a++; else n_b++;
            end
        end
        check("t3 acks to A", n_a, 3);
        check("t3 acks to B", n_b, 2);
        req_a[0] = 0; req_b[0] = 0;
        step();

        // Fixed priority: A starves B until A drops.
        req_a[1] = 1; we_a[1] = 1; addr_a[1] = 3'd4; wdata_a[1] = 8'h5A;
        req_b[1] = 1; we_b[1] = 0; addr_b[1] = 3'd4;
        n_a = 0; n_b = 0;
        for (int i = 0; i < 20 && n_a < 4; i++) begin
            step();
            if (ack_a[1]) n_a++;
            if (ack_b[1]) n_b++;
        end
        check("t4 A acks", n_a, 4);
        check("t4 B starved", n_b, 0);
        req_a[1] = 0;
        wait_ack(1, 1, lat, rws);
        check("t4 B latency", lat, 3);
        check("t4 B reads A data", rd_data[1], 8'h5A);
        req_b[1] = 0;
        step();

        // Isolation: B writes addr 7 while A reads addr 0.
        req_a[0] = 1; we_a[0] = 1; addr_a[0] = 3'd0; wdata_a[0] = 8'h11;
        wait_ack(0, 0, lat, rws);
        check("t5 preload latency", lat, 2);
        req_a[0] = 0;
        step();
        req_b[0] = 1; we_b[0] = 1; addr_b[0] = 3'd7; wdata_b[0] = 8'h3C;
        req_a[0] = 1; we_a[0] = 0; addr_a[0] = 3'd0;
        got_a = 0; got_b = 0; a_data = '0;
        for (int i = 0; i < 12 && !(got_a && got_b); i++) begin
            step();
            if (ack_b[0]) begin got_b = 1; req_b[0] = 0; end
            if (ack_a[0]) begin got_a = 1; a_data = rd_data[0]; req_a[0] = 0; end
        end
        check("t5 A acked", got_a, 1);
        check("t5 B acked", got_b, 1);
        check("t5 A read data", a_data, 8'h11);
        step();
        req_a[0] = 1; we_a[0] = 0; addr_a[0] = 3'd7;
        wait_ack(0, 0, lat, rws);
        check("t5 read addr7", rd_data[0], 8'h3C);
        req_a[0] = 0;
        step();
        for (int i = 0; i < 8; i++) check($sformatf("t5 ram[%0d]", i), ram[0][i], m_mem[0][i]);

        // Clear in the GRANT cycle of a write.
        req_a[0] = 1; we_a[0] = 1; addr_a[0] = 3'd5; wdata_a[0] = 8'hFF;
        step();
        check("t6 in grant write", ram_rw[0], 1'b1);
        clear[0] = 1'b1;
        step();
        check("t6 no ack", ack_a[0], 1'b0);
        check("t6 idle", busy[0], 1'b0);
        clear[0] = 1'b0;
        req_a[0] = 0;
        step();
        check("t6 still no ack", ack_a[0], 1'b0);
        check("t6 addr5 not FF", ram[0][5] == 8'hFF, 1'b0);

        // Randomized traffic with occasional clears.
        a_ok = 0; b_ok = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 2; k++) begin
                clear[k] = ($urandom_range(0, 99) == 0);
                if (ack_a[k]) a_ok++;
                if (ack_b[k]) b_ok++;
                if (!req_a[k] || ack_a[k] || $urandom_range(0, 15) == 0) begin
                    req_a[k] = ($urandom_range(0, 2) == 0);
                    we_a[k] = $urandom_range(0, 1);
                    addr_a[k] = AW'($urandom_range(0, 7));
                    wdata_a[k] = DW'($urandom);
                end
                if (!req_b[k] || ack_b[k] || $urandom_range(0, 15) == 0) begin
                    req_b[k] = ($urandom_range(0, 2) == 0);
                    we_b[k] = $urandom_range(0, 1);
                    addr_b[k] = AW'($urandom_range(0, 7));
                    wdata_b[k] = DW'($urandom);
                end
            end
            step();
        end
        check("rand A traffic seen", a_ok > 20, 1'b1);
        check("rand B traffic seen", b_ok > 20, 1'b1);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("final i%0d ram[%0d]", k, i), ram[k][i], m_mem[k][i]);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
